// File: rtl/imem_loader_pkg.sv
// Shared encodings for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam logic [2:0] ST_HEADER = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hB007;

  // States in which the stream input is accepted (and the loader is busy).
  function automatic logic st_accepts(input logic [2:0] st);
    return (st == ST_HEADER) || (st == ST_LOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_xor_accum.sv
// 32-bit XOR accumulator; clear takes priority over enable.
module loader_xor_accum (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] acc_o
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 32'd0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= 32'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/imem_prog_loader.sv
// Holds the processor in reset while a framed program (header, N words, XOR
// checksum) is streamed into instruction memory; releases it after a good load.
module imem_prog_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter logic [15:0] MAGIC  = DEFAULT_MAGIC
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              acc_clr, acc_en;
  logic [31:0]       csum;
  logic              xfer;
  logic [ADDR_W:0]   wl_inc;

  assign in_ready = st_accepts(state_q);
  assign xfer     = in_valid && in_ready;
  assign wl_inc   = wl_q + 1'b1;

  loader_xor_accum u_accum (
    .clk_i  (ref_clk),
    .rst_ni (reset),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .data_i (in_data),
    .acc_o  (csum)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wl_d    = wl_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    // reload wins over any coincident handshake; that word is dropped
    if (reload) begin
      state_d = ST_HEADER;
      err_d   = ERR_NONE;
      wl_d    = '0;
      len_d   = '0;
      acc_clr = 1'b1;
    end else if (xfer) begin
      case (state_q)
        ST_HEADER: begin
          if (in_data[31:16] != MAGIC) begin
            state_d = ST_ERROR;
            err_d   = ERR_MAGIC;
          end else if ((in_data[15:0] == 16'd0) || ({16'd0, in_data[15:0]} > DEPTH)) begin
            state_d = ST_ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d = ST_LOAD;
            len_d   = in_data[ADDR_W:0];
            wl_d    = '0;
            acc_clr = 1'b1;
          end
        end
        ST_LOAD: begin
          we_d    = 1'b1;
          waddr_d = wl_q[ADDR_W-1:0];
          wdata_d = in_data;
          acc_en  = 1'b1;
          wl_d    = wl_inc;
          if (wl_inc == len_q) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (in_data == csum) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      state_q <= ST_HEADER;
      err_q   <= ERR_NONE;
      wl_q    <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = (state_q == ST_RUN);
  assign done         = (state_q == ST_RUN);
  assign busy         = st_accepts(state_q);
  assign error        = (state_q == ST_ERROR);
  assign err_code     = err_q;
  assign words_loaded = wl_q;

endmodule
